// File: rtl/ibex_counter_arbiter.sv
// Round-robin arbiter sharing one counter-unit bus among NUM_REQ requesters.
// One outstanding transaction, registered issue/response, response timeout.
module ibex_counter_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*32-1:0] addr_i,
  input  logic [NUM_REQ*32-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  spurious_o,
  output logic                  counter_req_o,
  output logic                  counter_we_o,
  output logic [31:0]           counter_addr_o,
  output logic [31:0]           counter_wdata_o,
  input  logic                  counter_rvalid_i,
  input  logic [31:0]           counter_rdata_i,
  input  logic                  counter_err_i
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 spur_q, spur_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 creq_q, creq_d;

  logic                 found;
  logic [IW-1:0]        sel;
  logic [IW:0]          cand;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic [CW-1:0]        cnt_inc;
  logic                 expire;

  // First requester at or above the rr pointer, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  // Pick the winner's address and write data
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IW'(k)) begin
        sel_addr  = addr_i[32*k +: 32];
        sel_wdata = wdata_i[32*k +: 32];
      end
    end
  end

  // Saturating wait counter and expiry detect
  always_comb begin
    cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    expire  = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    spur_d   = spur_q | (counter_rvalid_i && state_q != WAIT);
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    creq_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ISSUE;
          owner_d    = sel;
          we_d       = we_i[sel];
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          gnt_d[sel] = 1'b1;
          creq_d     = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
      end
      WAIT: begin
        if (counter_rvalid_i) begin
          state_d           = IDLE;
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = counter_rdata_i;
          err_d             = counter_err_i;
        end else begin
          cnt_d = cnt_inc;
          if (expire) begin
            state_d           = IDLE;
            rvalid_d[owner_q] = 1'b1;
            rdata_d           = '0;
            err_d             = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      spur_q   <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      creq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      spur_q   <= spur_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      creq_q   <= creq_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign rvalid_o        = rvalid_q;
  assign rdata_o         = rdata_q;
  assign err_o           = err_q;
  assign busy_o          = (state_q != IDLE);
  assign spurious_o      = spur_q;
  assign counter_req_o   = creq_q;
  assign counter_we_o    = we_q;
  assign counter_addr_o  = addr_q;
  assign counter_wdata_o = wdata_q;

endmodule

// File: tb/tb_ibex_counter_arbiter.sv
// Self-checking bench for ibex_counter_arbiter (NUM_REQ=2, TIMEOUT=16).
// Directed scenarios plus randomized transactions against a cycle model.
module tb_ibex_counter_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_i, we_i;
  logic [N*32-1:0] addr_i, wdata_i;
  logic [N-1:0]  gnt_o, rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o, busy_o, spurious_o;
  logic          counter_req_o, counter_we_o;
  logic [31:0]   counter_addr_o, counter_wdata_o;
  logic          counter_rvalid_i;
  logic [31:0]   counter_rdata_i;
  logic          counter_err_i;

  int passed = 0;
  int total  = 0;
  int rr_m   = 0;

  ibex_counter_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .busy_o(busy_o), .spurious_o(spurious_o),
    .counter_req_o(counter_req_o),
    .counter_we_o(counter_we_o),
    .counter_addr_o(counter_addr_o),
    .counter_wdata_o(counter_wdata_o),
    .counter_rvalid_i(counter_rvalid_i),
    .counter_rdata_i(counter_rdata_i),
    .counter_err_i(counter_err_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One transaction from IDLE. d: response delay after ISSUE
  // (1..TO gives real data, 0 means target never answers).
  task automatic do_txn(input logic [1:0]  mask,
                        input int          d,
                        input logic        e,
                        input logic [31:0] rd,
                        input logic [1:0]  wem,
                        input logic [63:0] addrs,
                        input logic [63:0] wdatas);
    int w;
    int resp;
    bit hit;
    logic [31:0] exp_rd;
    logic        exp_err;
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && mask[(rr_m + i) % N]) w = (rr_m + i) % N;
    hit     = (d >= 1 && d <= TO);
    resp    = hit ? 2 + d : TO + 2;
    exp_rd  = hit ? rd : 32'h0;
    exp_err = hit ? e : 1'b1;
    req_i  = mask;
    we_i   = wem;
    addr_i = addrs;
    wdata_i = wdatas;
    tick;
    chk("gnt", 32'(gnt_o), 32'(1 << w));
    chk("creq", 32'(counter_req_o), 32'd1);
    chk("caddr", counter_addr_o, addrs[32*w +: 32]);
    chk("cwe", 32'(counter_we_o), 32'(wem[w]));
    chk("cwdata", counter_wdata_o, wdatas[32*w +: 32]);
    chk("busy_issue", 32'(busy_o), 32'd1);
    req_i = '0;
    rr_m  = (w + 1) % N;
    for (int c = 1; c < resp; c++) begin
      counter_rvalid_i = hit && (c == 1 + d);
      counter_rdata_i  = rd;
      counter_err_i    = e;
      tick;
      counter_rvalid_i = 1'b0;
      counter_rdata_i  = $urandom;
      counter_err_i    = 1'($urandom);
      if (c + 1 < resp) begin
        chk("rvalid_wait", 32'(rvalid_o), 32'd0);
        chk("creq_wait", 32'(counter_req_o), 32'd0);
      end
    end
    chk("rvalid", 32'(rvalid_o), 32'(1 << w));
    chk("rdata", rdata_o, exp_rd);
    chk("err", 32'(err_o), 32'(exp_err));
    chk("busy_done", 32'(busy_o), 32'd0);
    tick;
    chk("rvalid_pulse", 32'(rvalid_o), 32'd0);
    chk("rdata_hold", rdata_o, exp_rd);
  endtask

  initial begin
    logic [31:0] spur_exp;
    rst_i = 1'b1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    counter_rvalid_i = 1'b0; counter_rdata_i = '0; counter_err_i = 1'b0;
    tick; tick;
    rst_i = 1'b0;
    tick;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_spur", 32'(spurious_o), 32'd0);
    chk("rst_creq", 32'(counter_req_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);

    // Single read from requester 0
    do_txn(2'b01, 3, 1'b0, 32'hDEADBEEF, 2'b00,
           {32'h1111_0000, 32'h0000_0B00}, 64'h0);

    // Write from requester 1 with error response
    do_txn(2'b10, 2, 1'b1, 32'h5555_AAAA, 2'b10,
           {32'h0000_0C04, 32'h0}, {32'h0000_1234, 32'h0});

    // Timeout: target never answers
    do_txn(2'b01, 0, 1'b0, 32'h0, 2'b00,
           {32'h0, 32'h0000_0B10}, 64'h0);

    // Collision: rvalid in the cycle the count reaches TIMEOUT
    do_txn(2'b10, TO, 1'b0, 32'hCAFE_F00D, 2'b00,
           {32'h0000_0B20, 32'h0}, 64'h0);

    // Both hold requests; target answers two cycles after ISSUE
    begin
      int own [$];
      req_i = 2'b11;
      for (int c = 1; c <= 12; c++) begin
        tick;
        if (c % 4 == 1) begin
          chk("rr_gnt", 32'(gnt_o), 32'(1 << rr_m));
          own.push_back(rr_m);
          rr_m = (rr_m + 1) % N;
        end else begin
          chk("rr_nogap", 32'(gnt_o), 32'd0);
        end
        if (c % 4 == 0)
          chk("rr_rvalid", 32'(rvalid_o), 32'(1 << own.pop_front()));
        counter_rvalid_i = (c % 4 == 3);
        counter_rdata_i  = 32'(c);
        counter_err_i    = 1'b0;
        if (c == 12) req_i = '0;
      end
      counter_rvalid_i = 1'b0;
      tick;
      chk("rr_idle", 32'(busy_o), 32'd0);
    end

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [1:0] m;
      int dly;
      m = 2'($urandom_range(1, 3));
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      do_txn(m, dly, 1'($urandom), $urandom, 2'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom});
    end

    // Reset in WAIT, then a late response
    req_i = 2'b10;
    tick;
    chk("pre_rst_gnt", 32'(gnt_o), 32'(1 << 1'b1) & (rr_m == 1 ? 32'd2 : 32'd0) | (rr_m == 0 ? 32'd2 : 32'd0));
    req_i = '0;
    tick; tick; tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    rr_m  = 0;
    chk("wrst_busy", 32'(busy_o), 32'd0);
    chk("wrst_addr", counter_addr_o, 32'd0);
    chk("wrst_spur", 32'(spurious_o), 32'd0);
    counter_rvalid_i = 1'b1;
    counter_rdata_i  = 32'h7777_7777;
    tick;
    counter_rvalid_i = 1'b0;
    chk("late_rvalid", 32'(rvalid_o), 32'd0);
    spur_exp = 32'd1;
    chk("late_spur", 32'(spurious_o), spur_exp);
    tick;
    chk("late_rvalid2", 32'(rvalid_o), 32'd0);
    do_txn(2'b11, 1, 1'b0, 32'h0BAD_CAFE, 2'b00,
           {32'h0000_0D00, 32'h0000_0D04}, 64'h0);
    chk("spur_sticky", 32'(spurious_o), spur_exp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
